// File: rtl/handshake_master_fifo.sv
// Valid/ready source stage: a producer writes words on wr_en, they are buffered
// in a small FIFO behind an output register and presented downstream in order.
module handshake_master_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SKIP_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(DEPTH+2)-1:0]    count,
  output logic [WIDTH-1:0]              data_out,
  output logic                          data_valid,
  input  logic                          data_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+2);

  // Handshake: a word moves downstream on a rising edge where data_valid=1 and
  // data_ready=1; data_valid only falls after such a transfer and data_out is
  // frozen while data_valid=1 and data_ready=0.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_next;

  logic             skip;
  logic             write_req;
  logic             accept;
  logic             drop;
  logic             xfer;
  logic             out_free;
  logic             fifo_empty;
  logic             pop;
  logic             bypass;
  logic             push;
  logic             valid_next;
  logic             full_next;
  logic [CW-1:0]    count_next;

  always_comb begin
    skip       = 1'b0;
    write_req  = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    xfer       = 1'b0;
    out_free   = 1'b0;
    fifo_empty = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    push       = 1'b0;
    valid_next = data_valid;
    occ        = wr_ptr - rd_ptr;
    occ_next   = occ;
    full_next  = 1'b0;
    count_next = count;

    skip       = (SKIP_ZERO != 0) && (data_in == '0);
    write_req  = wr_en && !skip;
    // The registered full flag gates acceptance even if a slot frees this cycle.
    accept     = write_req && !full;
    drop       = write_req && full;
    xfer       = data_valid && data_ready;
    out_free   = !data_valid || xfer;
    fifo_empty = (wr_ptr == rd_ptr);
    pop        = out_free && !fifo_empty;
    bypass     = out_free && fifo_empty && accept;
    push       = accept && !bypass;

    if (pop || bypass) begin
      valid_next = 1'b1;
    end else if (xfer) begin
      valid_next = 1'b0;
    end

    occ_next   = occ + (AW+1)'(push) - (AW+1)'(pop);
    full_next  = (occ_next == (AW+1)'(DEPTH));
    count_next = count + CW'(accept) - CW'(xfer);
  end

  // Array storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        data_out <= mem[rd_ptr[AW-1:0]];
      end else if (bypass) begin
        data_out <= data_in;
      end
      data_valid <= valid_next;
      full       <= full_next;
      overflow   <= drop;
      count      <= count_next;
    end
  end

endmodule

// File: tb/tb_handshake_master_fifo.sv
// Directed and random bench for handshake_master_fifo with a queue-based
// reference model checked every cycle, plus a SKIP_ZERO=0 instance.
module tb_handshake_master_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+2);

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance (SKIP_ZERO=1)
  logic          wr_en = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_ready = 1'b0;
  logic          full;
  logic          overflow;
  logic [CW-1:0] count;
  logic [W-1:0]  data_out;
  logic          data_valid;

  // Second instance (SKIP_ZERO=0)
  logic          wr_b = 1'b0;
  logic [W-1:0]  din_b = '0;
  logic          rdy_b = 1'b0;
  logic          full_b;
  logic          overflow_b;
  logic [CW-1:0] count_b;
  logic [W-1:0]  data_out_b;
  logic          data_valid_b;

  handshake_master_fifo #(.WIDTH(W), .DEPTH(DEPTH), .SKIP_ZERO(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .full(full), .overflow(overflow), .count(count),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
  );

  handshake_master_fifo #(.WIDTH(W), .DEPTH(DEPTH), .SKIP_ZERO(0)) u_nz (
    .clk(clk), .rst(rst), .wr_en(wr_b), .data_in(din_b),
    .full(full_b), .overflow(overflow_b), .count(count_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_ready(rdy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words pushed on predicted acceptance, popped on transfer.
  logic [W-1:0] exp_q[$];
  logic         m_full = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_req;
  logic         m_acc;
  logic         m_xfer;

  // Inputs change only at posedge+1, so at negedge they are what the next
  // edge will sample and the DUT outputs reflect the previous edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
      check("rst_valid", data_valid, 0);
      check("rst_count", count, 0);
      check("rst_data", data_out, 0);
    end else begin
      check("valid", data_valid, exp_q.size() != 0);
      check("count", count, exp_q.size());
      check("full", full, m_full);
      check("overflow", overflow, m_ovf);
      if (exp_q.size() != 0) check("data", data_out, exp_q[0]);
      m_req  = wr_en && (data_in != '0);
      m_acc  = m_req && !m_full;
      m_xfer = (exp_q.size() != 0) && data_ready;
      m_ovf  = m_req && m_full;
      if (m_xfer) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back(data_in);
      m_full = (exp_q.size() == DEPTH + 1);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [W-1:0] din, input logic rdy);
    wr_en      = wr;
    data_in    = din;
    data_ready = rdy;
  endtask

  int thr;

  initial begin
    // Power-on reset
    repeat (3) tick();
    check("por_valid", data_valid, 0);
    check("por_full", full, 0);
    check("por_overflow", overflow, 0);
    rst = 1'b1;

    // Reset mid-transfer
    tick(); drive(1, 8'h11, 0);
    tick(); drive(1, 8'h22, 0);
    tick(); drive(0, 8'h00, 0);
    check("pre_rst_count", count, 2);
    #2 rst = 1'b0;
    #1;
    check("async_valid", data_valid, 0);
    check("async_count", count, 0);
    check("async_full", full, 0);
    tick(); rst = 1'b1; drive(0, 8'h00, 1);
    repeat (3) begin
      tick();
      check("post_rst_idle", data_valid, 0);
    end

    // Bypass latency
    drive(1, 8'h5a, 1);
    tick(); drive(0, 8'h00, 1);
    check("bypass_valid", data_valid, 1);
    check("bypass_data", data_out, 8'h5a);
    tick();
    check("bypass_done_valid", data_valid, 0);
    check("bypass_done_count", count, 0);

    // Stall, hold, overflow
    drive(1, 8'h01, 0);
    for (int i = 2; i <= 5; i++) begin
      tick(); drive(1, W'(i), 0);
    end
    tick(); drive(0, 8'h00, 0);
    check("stall_count", count, 5);
    check("stall_full", full, 1);
    check("stall_data", data_out, 8'h01);
    tick(); drive(1, 8'h06, 0);
    tick(); drive(0, 8'h00, 0);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 5);
    tick();
    check("ovf_clear", overflow, 0);
    check("stall_hold", data_out, 8'h01);
    drive(0, 8'h00, 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("drain_data", data_out, i);
    end
    tick();
    check("drain_empty", data_valid, 0);
    check("drain_count", count, 0);

    // Zero skip on the SKIP_ZERO=1 instance
    drive(1, 8'h00, 1);
    tick(); drive(1, 8'h33, 1);
    check("skip_zero_first", data_valid, 0);
    tick(); drive(1, 8'h00, 1);
    check("skip_data", data_out, 8'h33);
    tick(); drive(0, 8'h00, 1);
    check("skip_tail_valid", data_valid, 0);
    check("skip_overflow", overflow, 0);

    // Zero pass-through on the SKIP_ZERO=0 instance
    wr_b = 1'b1; din_b = 8'h00; rdy_b = 1'b1;
    tick(); din_b = 8'h33;
    check("nz_valid0", data_valid_b, 1);
    check("nz_data0", data_out_b, 8'h00);
    tick(); din_b = 8'h00;
    check("nz_data1", data_out_b, 8'h33);
    tick(); wr_b = 1'b0;
    check("nz_data2", data_out_b, 8'h00);
    check("nz_count", count_b, 1);
    tick();
    check("nz_done", data_valid_b, 0);
    check("nz_overflow", overflow_b, 0);

    // Simultaneous push/pop with FIFO at DEPTH-1
    drive(1, 8'ha1, 0);
    tick(); drive(1, 8'ha2, 0);
    tick(); drive(1, 8'ha3, 0);
    tick(); drive(1, 8'ha4, 0);
    tick(); drive(1, 8'h77, 1);
    check("pp_pre_count", count, 4);
    tick(); drive(0, 8'h00, 0);
    check("pp_count", count, 4);
    check("pp_full", full, 0);
    check("pp_head", data_out, 8'ha2);
    drive(0, 8'h00, 1);
    tick(); check("pp_data_a3", data_out, 8'ha3);
    tick(); check("pp_data_a4", data_out, 8'ha4);
    tick(); check("pp_data_77", data_out, 8'h77);
    tick(); check("pp_empty", data_valid, 0);

    // Random soak, ready bias varied to reach both full and empty
    for (int n = 0; n < 10000; n++) begin
      tick();
      case ((n / 1000) % 3)
        0: thr = 20;
        1: thr = 90;
        default: thr = 50;
      endcase
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom_range(0, 255)),
            $urandom_range(0, 99) < thr);
    end
    tick(); drive(0, 8'h00, 1);
    repeat (8) tick();
    check("soak_drained_count", count, 0);
    check("soak_drained_valid", data_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_master_fifo.md
Name: handshake_master_fifo

Overview:
- Parametrised valid/ready source stage: accepts words from a local producer on a write strobe and presents them downstream one at a time on data_out/data_valid, holding each word until data_ready.
- Next generation of the single-register handshaking master: configurable width and buffering depth, zero-word filtering as a mode, overflow reporting and occupancy output.
- Sits between a producer, which never stalls, and any handshaking slave in the communication-protocol blocks.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, entries in the internal FIFO array, excluding the output register. Power of two, >=2.
- SKIP_ZERO, 1, when 1 a write of an all-zero word is silently ignored; when 0 zero words are transferred normally.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, deasserted synchronously to clk by the system.
- wr_en  input  1  producer write strobe, one word per cycle when high.
- data_in  input  WIDTH  producer word, sampled when wr_en=1.
- full  output  1  registered; 1 when the FIFO array holds DEPTH entries.
- overflow  output  1  registered one-cycle pulse: a non-skipped write was dropped because full=1.
- count  output  $clog2(DEPTH+2)  registered words held: FIFO occupancy plus data_valid. Range 0..DEPTH+1.
- data_out  output  WIDTH  registered downstream word.
- data_valid  output  1  registered; 1 while data_out holds an untransferred word.
- data_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=0, async): data_out=0, data_valid=0, full=0, overflow=0, count=0. FIFO read/write pointers are cleared and contents are discarded. A transfer in flight is abandoned, not completed.
- Transfer: occurs on a rising edge with data_valid=1 and data_ready=1.
- Handshake rules:
  - data_valid never drops without a transfer.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_ready may be asserted before data_valid and may be held high continuously.
- Accepted write: wr_en=1, and not (SKIP_ZERO=1 and data_in==0), and full=0.
- Dropped write: wr_en=1, not skipped, full=1. The word is lost; overflow=1 on the next cycle.
  - The full check uses the registered full value, even if a transfer frees a slot in the same cycle.
- Skipped write: does not change state and does not raise overflow.
- Output register load, priority per edge:
  - a) If the output register is empty or transferring, and the FIFO is non-empty: load the FIFO head and pop.
  - b) Else if the output register is empty or transferring, the FIFO is empty, and a write is accepted: bypass data_in directly into the output register; the FIFO is unchanged.
  - c) Else if the output register is transferring and nothing is available: data_valid goes to 0 and data_out holds its last value.
- An accepted write not consumed by bypass is pushed to the FIFO tail. A same-cycle push and pop is legal at any occupancy below DEPTH.
- Latency:
  - Write into an empty block: data_valid=1 with that word on the next edge (1 cycle).
  - Back-to-back: with data_ready held at 1, throughput is one word per cycle with no bubbles.
- Ordering: strict FIFO; words leave in acceptance order.
- count is next-state consistent: count' = count + accepted - transferred.
- full' = (FIFO occupancy' == DEPTH).
- Pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.

Test Plan:
- Reset mid-transfer: load 0x11, 0x22; hold data_ready=0; pull rst low → data_valid=0, count=0, full=0 immediately (before next edge); after release, data_ready=1 with no writes → no data_valid.
- Bypass latency: WIDTH=8, empty block; write 0x5A once with data_ready=1 → cycle+1 data_valid=1, data_out=0x5A; cycle+2 data_valid=0, count=0.
- Stall and hold: data_ready=0; write 0x01..0x05 on consecutive cycles (DEPTH=4) → data_out=0x01 stable, count=5, full=1. Then a write of 0x06 → overflow pulses 1 cycle, count stays 5. Then data_ready=1 → output sequence 0x01..0x05, one per cycle, no 0x06.
- Zero skip: SKIP_ZERO=1, write 0x00, 0x33, 0x00 → only 0x33 is emitted, count peaks at 1, overflow never asserts. With SKIP_ZERO=0, the same stimulus emits 0x00, 0x33, 0x00.
- Simultaneous push/pop at full-1: FIFO holds 3 entries and the output register is valid. Write 0x77 with data_ready=1 → count unchanged (4), full stays 0, and 0x77 is emitted last.
- Random soak: random wr_en/data_in/data_ready for 10k cycles → scoreboard shows in-order delivery, data_out stable under stall, and count matching the model every cycle.
